// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that multiplexes several byte-stream
// requesters onto the single UART TX FIFO write port, with a per-grant burst limit.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_W-1:0]     req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        tx_fifo_full,
    output logic                        tx_wr_en,
    output logic [DATA_W-1:0]           tx_wr_data,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        busy
);

    localparam int unsigned GW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [GW-1:0]     r_rr_ptr;
    logic [GW-1:0]     w_rr_ptr_nxt;
    logic [GW-1:0]     r_grant_id;
    logic [GW-1:0]     w_grant_id_nxt;
    logic [CW-1:0]     r_burst_cnt;
    logic [CW-1:0]     w_burst_cnt_nxt;
    logic [CW-1:0]     w_cnt_inc;
    logic [GW-1:0]     w_sel;
    logic [GW-1:0]     w_cand;
    logic              w_any;
    int unsigned       w_idx;
    logic              w_xfer;
    logic              w_release;
    logic [DATA_W-1:0] w_lane;

    // Scan upward from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_idx  = 0;
        w_cand = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_idx = 32'(r_rr_ptr) + i;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            w_cand = GW'(w_idx);
            if (!w_any && req_valid[w_cand]) begin
                w_any = 1'b1;
                w_sel = w_cand;
            end
        end
    end

    assign w_lane    = req_data[r_grant_id*DATA_W +: DATA_W];
    assign w_cnt_inc = r_burst_cnt + CW'(1);
    assign w_xfer    = (r_state == LOCKED) && req_valid[r_grant_id] && !tx_fifo_full;
    // Packet end and burst limit on the same byte collapse into one release.
    assign w_release = w_xfer && (req_last[r_grant_id] || (w_cnt_inc == CW'(MAX_BURST)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_id_nxt  = r_grant_id;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt     = LOCKED;
                    w_grant_id_nxt  = w_sel;
                    w_burst_cnt_nxt = '0;
                end
            end
            LOCKED: begin
                if (w_xfer) begin
                    w_burst_cnt_nxt = w_cnt_inc;
                end
                if (w_release) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = (r_grant_id == GW'(N_REQ - 1)) ? '0 : r_grant_id + GW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        tx_wr_en   = 1'b0;
        tx_wr_data = '0;
        busy       = (r_state == LOCKED);
        if (r_state == LOCKED) begin
            req_ready[r_grant_id] = !tx_fifo_full;
        end
        if (w_xfer) begin
            tx_wr_en   = 1'b1;
            tx_wr_data = w_lane;
        end
    end

    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: a cycle-level reference model
// predicts every FIFO write, and a separate monitor compares the DUT against it.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_fifo_full;
    logic            tx_wr_en;
    logic [DW-1:0]   tx_wr_data;
    logic [1:0]      grant_id;
    logic            busy;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_fifo_full(tx_fifo_full),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] d;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    logic [8:0]  pq[N][$];
    exp_t        expq[$];
    int          pvalid = 100;
    int          pfull  = 0;
    logic [N-1:0] acc = '0;

    // reference model state: holder = -1 means nobody holds the port
    int          m_holder = -1;
    int          m_cnt    = 0;
    int          m_ptr    = 0;
    int          m_gid    = 0;
    logic        e_busy   = 1'b0;
    int          e_gid    = 0;
    logic [N-1:0] e_ready = '0;
    logic        e_wr     = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        acc = req_valid & req_ready;
        if (rst) begin
            m_holder = -1; m_cnt = 0; m_ptr = 0; m_gid = 0;
            e_busy = 1'b0; e_gid = 0; e_ready = '0; e_wr = 1'b0;
            acc = '0;
            expq.delete();
        end else begin
            e_busy  = (m_holder >= 0);
            e_gid   = m_gid;
            e_ready = '0;
            e_wr    = 1'b0;
            if (m_holder < 0) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (m_holder < 0 && req_valid[c]) begin
                        m_holder = c;
                        m_gid    = c;
                        m_cnt    = 0;
                    end
                end
            end else begin
                e_ready[m_holder] = !tx_fifo_full;
                if (req_valid[m_holder] && !tx_fifo_full) begin
                    exp_t e;
                    e.id = m_holder;
                    e.d  = req_data[m_holder*DW +: DW];
                    expq.push_back(e);
                    e_wr = 1'b1;
                    m_cnt++;
                    if (req_last[m_holder] || m_cnt == MB) begin
                        m_ptr    = (m_holder + 1) % N;
                        m_holder = -1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            check("busy", int'(busy), int'(e_busy));
            check("wr_en", int'(tx_wr_en), int'(e_wr));
            check("req_ready", int'(req_ready), int'(e_ready));
            if (e_busy) check("grant_id", int'(grant_id), e_gid);
            if (tx_wr_en) begin
                if (expq.size() == 0) begin
                    check("unexpected_wr", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("wr_data", int'(tx_wr_data), int'(e.d));
                    check("wr_src", int'(grant_id), e.id);
                end
            end else begin
                check("idle_data", int'(tx_wr_data), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0 && $urandom_range(99) < pvalid) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = pq[i][0][7:0];
                req_last[i]           = pq[i][0][8];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = 8'($urandom);
                req_last[i]           = 1'($urandom);
            end
        end
        tx_fifo_full = ($urandom_range(99) < pfull);
    endtask

    task automatic load_pkt(input int id, input int len);
        for (int b = 0; b < len; b++) begin
            logic [7:0] d;
            d = 8'($urandom);
            pq[id].push_back({(b == len - 1), d});
        end
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += pq[i].size();
        return s;
    endfunction

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (pending() > 0 && k < bound) begin
            step();
            k++;
        end
        check("drain_remaining", pending(), 0);
        repeat (3) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_wr_en"}, int'(tx_wr_en), 0);
        check({tag, "_wr_data"}, int'(tx_wr_data), 0);
        check({tag, "_ready"}, int'(req_ready), 0);
        check({tag, "_gid"}, int'(grant_id), 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0; tx_fifo_full = 1'b0;
        #1;
        check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single packet from requester 2
        pq[2].push_back(9'h041); pq[2].push_back(9'h042); pq[2].push_back(9'h143);
        pvalid = 100; pfull = 0;
        drain(40);

        // burst limit: requester 3 streams 20 bytes while requester 0 waits
        load_pkt(3, 20); load_pkt(0, 2);
        drain(100);

        // backpressure on a single 4-byte packet
        load_pkt(0, 4); pfull = 40;
        drain(100);

        // reset in the middle of a 5-byte packet from requester 1
        pfull = 0;
        load_pkt(1, 5);
        repeat (3) step();
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        drain(100);

        // randomized contention with stalls and backpressure
        for (int r = 0; r < 3; r++) begin
            pvalid = 60 + 15 * r; pfull = 10 + 15 * r;
            for (int i = 0; i < N; i++) begin
                for (int p = 0; p < 3; p++) load_pkt(i, 1 + $urandom_range(23));
            end
            drain(4000);
        end

        check("scoreboard_left", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locking arbiter sharing the single UART transmit FIFO write port among several byte-stream requesters (debug console, DMA, firmware mailbox, ...). Sits between the requesters and the UART TX FIFO. A grant is held for a whole packet so bytes from different sources never interleave on the line. A burst limit forces release so one requester cannot starve the others.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width of each requester data lane
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  requester i has a byte on its lane
- req_data  in  N_REQ*DATA_W  lane i = bits [i*DATA_W +: DATA_W]
- req_last  in  N_REQ  byte on lane i is the final byte of its packet
- req_ready  out  N_REQ  byte on lane i is accepted this cycle
- tx_fifo_full  in  1  UART TX FIFO cannot accept a write
- tx_wr_en  out  1  write strobe to the UART TX FIFO
- tx_wr_data  out  DATA_W  byte to write
- grant_id  out  clog2(N_REQ)  index of the current grant holder
- busy  out  1  a grant is active

## Operation
- FSM states: IDLE, LOCKED.
- IDLE:
  - If any req_valid is high, select the first requester at or after rr_ptr, scanning upward with wrap.
  - Register that index into grant_id, clear burst_cnt, go to LOCKED.
  - No byte is transferred in IDLE.
- LOCKED, with g = grant_id:
  - req_ready[g] = !tx_fifo_full. All other req_ready bits are 0.
  - Transfer occurs when req_valid[g] && req_ready[g].
  - On a transfer: tx_wr_en = 1, tx_wr_data = lane g, burst_cnt increments.
  - tx_wr_en and tx_wr_data are combinational from the lane; no extra register stage.
- Release: on a transfer with req_last[g] = 1, or a transfer making burst_cnt == MAX_BURST, go to IDLE next cycle and set rr_ptr = (g+1) mod N_REQ.
- While LOCKED, req_valid[g] low means wait. The grant is held indefinitely and there is no timeout.
- A forced release mid-packet (MAX_BURST reached) does not alter the data. The requester re-arbitrates for the remainder.
- burst_cnt width is clog2(MAX_BURST+1). It never wraps, because release occurs at MAX_BURST.
- tx_wr_data is 0 whenever tx_wr_en is 0.
- busy = (state == LOCKED).

## Timing
- Reset values: state IDLE, rr_ptr 0, grant_id 0, burst_cnt 0, busy 0, req_ready 0, tx_wr_en 0, tx_wr_data 0.
- Arbitration latency: req_valid rises in IDLE at cycle T, grant registered at T+1, earliest byte write at T+1.
- Throughput while LOCKED: one byte per cycle when valid is high and the FIFO is not full.
- Inter-packet gap: exactly one IDLE cycle between a release and the next grant.
- tx_fifo_full high: req_ready[g] and tx_wr_en are low in that same cycle. No byte is lost or duplicated.
- req_last and MAX_BURST reached on the same byte: a single release; rr_ptr advances once.
- Only the granted requester pending again in IDLE: it is re-granted. Round-robin only changes order among contenders.
- rst asserted mid-packet: all outputs return to their reset values immediately (asynchronously). The partial packet is abandoned and no write occurs while rst is high.
- req_valid bits for non-granted requesters may change freely and have no effect while LOCKED.

## Test plan
- Single packet: N_REQ=4. Req 2 sends 0x41,0x42,0x43 with last on 0x43, valid at cycle 0. Expect grant_id=2 and busy at cycle 1, tx_wr_en on cycles 1–3 with data 0x41/0x42/0x43, IDLE at cycle 4, rr_ptr=3.
- Round-robin: reqs 0 and 1 each hold 2-byte packets from cycle 0. Expect req 0 bytes at cycles 1–2, gap at cycle 3, req 1 bytes at cycles 4–5. Repeat with req 0 pending again; expect req 1 then req 0 order after rr_ptr wraps.
- FIFO backpressure: req 0 sends 4 bytes and tx_fifo_full is high for cycles 2–4. Expect req_ready[0]=0 and tx_wr_en=0 on those cycles, bytes 2–4 on cycles 5–7, order preserved.
- Burst limit: MAX_BURST=16. Req 3 streams 20 bytes with last on byte 20 while req 0 is pending. Expect release after byte 16, req 0 served next, then req 3 resumes with byte 17.
- Reset mid-packet: assert rst after byte 2 of a 5-byte packet from req 1. Expect busy=0, tx_wr_en=0, req_ready=0 immediately. After reset releases, req 1 is re-granted from arbitration with rr_ptr=0.
- Stall with valid low: the granted req 2 drops valid for 5 cycles mid-packet while req 0 is pending. Expect grant_id to stay 2, no writes during the gap, and the packet to complete before req 0 is granted.
